// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing the single write port of a FIFO
//               among NUM_REQ producers. One registered write per grant;
//               FIFO free space is tracked with a credit counter so a write
//               is never issued into a full FIFO.
//               Optional protocol checker enabled by macro ARB_ERR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_wr_en_o,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in_o,
  input  logic                          fifo_rd_en_i,
  input  logic                          fifo_empty_i,
  input  logic                          fifo_wr_ack_i,
  input  logic                          fifo_overflow_i,
  output logic [CW-1:0]                 credits_o,
  output logic                          err_o
);

  localparam int            PW           = $clog2(NUM_REQ);
  localparam logic [CW-1:0] c_CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_CREDIT_ONE = CW'(1);
  localparam logic [PW-1:0] c_PTR_RST    = PW'(NUM_REQ - 1);

  // Registered state
  logic [NUM_REQ-1:0]    gnt_q,      gnt_d;
  logic                  wr_en_q,    wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q,     data_d;
  logic [CW-1:0]         credits_q,  credits_d;
  logic [PW-1:0]         last_ptr_q, last_ptr_d;

  // Arbitration wires
  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_found;
  logic [PW-1:0]         w_pick;
  logic [PW-1:0]         w_cand;
  int                    w_idx;
  logic                  w_issue;
  logic                  w_inc;
  logic                  w_sat_inc;

  // Round-robin search: first eligible producer after last_ptr, wrapping.
  // A producer granted this cycle is masked so it cannot be granted twice
  // before it has seen its gnt pulse and updated req/data.
  always_comb begin
    w_elig  = req_i & ~gnt_q;
    w_found = 1'b0;
    w_pick  = last_ptr_q;
    w_cand  = '0;
    w_idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = int'(last_ptr_q) + off;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_cand = PW'(w_idx);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Credit events sampled at this edge: a write consumes one entry, a real
  // read (not on an empty FIFO) frees one.
  always_comb begin
    w_issue   = w_found && (credits_q != '0);
    w_inc     = fifo_rd_en_i && !fifo_empty_i;
    w_sat_inc = w_inc && !w_issue && (credits_q == c_CREDIT_MAX);
  end

  // Next-state for grant, write port and pointer.
  always_comb begin
    gnt_d      = '0;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    last_ptr_d = last_ptr_q;
    if (w_issue) begin
      gnt_d      = NUM_REQ'(1) << w_pick;
      wr_en_d    = 1'b1;
      data_d     = req_data_i[int'(w_pick)*FIFO_WIDTH +: FIFO_WIDTH];
      last_ptr_d = w_pick;
    end
  end

  // Next-state for the credit counter; simultaneous write and read cancel,
  // an increment while already full saturates.
  always_comb begin
    credits_d = credits_q;
    case ({w_inc, w_issue})
      2'b01:   credits_d = credits_q - c_CREDIT_ONE;
      2'b10:   if (credits_q != c_CREDIT_MAX) credits_d = credits_q + c_CREDIT_ONE;
      default: credits_d = credits_q;
    endcase
  end

  // State register; reset aborts any write or grant in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      credits_q  <= c_CREDIT_MAX;
      last_ptr_q <= c_PTR_RST;
    end else begin
      gnt_q      <= gnt_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      credits_q  <= credits_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_data_in_o = data_q;
  assign credits_o      = credits_q;

`ifdef ARB_ERR_CHK_EN
  // The FIFO acknowledges one cycle after it captures the word, so the ack
  // is checked against the write enable of the cycle before the one ending.
  logic wr_prev_q, wr_prev_d;
  logic err_q,     err_d;

  // Sticky error: overflow, missing ack, or a read freeing a slot when
  // the arbiter already believes the FIFO is empty.
  always_comb begin
    wr_prev_d = wr_en_q;
    err_d     = err_q;
    if (fifo_overflow_i || (wr_prev_q && !fifo_wr_ack_i) || w_sat_inc) begin
      err_d = 1'b1;
    end
  end

  // Checker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_prev_q <= wr_prev_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Checker not built; its inputs are intentionally left unconsumed.
  logic w_unused_chk;
  assign w_unused_chk = fifo_wr_ack_i ^ fifo_overflow_i ^ w_sat_inc;
  assign err_o        = 1'b0;
`endif

endmodule

`default_nettype wire
